leds_pwm: RTL and testbench

Memory-mapped LED output controller for the d16 I/O bus. Next-generation successor to the plain LED latch, with parametrised LED count, a global PWM brightness and a per-LED blink mask driven by a shared timebase. Sits on the peripheral bus beside the other I/O blocks and drives board LED pins directly.

---
 rtl/leds_pkg.sv | 13 +
 rtl/leds_timebase.sv | 63 ++++++
 rtl/leds_pwm.sv | 101 ++++++++++
 tb/tb_leds_pwm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared register map and reset constants for the LED PWM controller.
package leds_pkg;

  localparam logic [1:0] ADDR_ON    = 2'd0;
  localparam logic [1:0] ADDR_BLINK = 2'd1;
  localparam logic [1:0] ADDR_DUTY  = 2'd2;
  localparam logic [1:0] ADDR_HALF  = 2'd3;

  // Wide enough for the largest PWM_BITS; sliced down at the use site.
  localparam logic [7:0]  DUTY_RST = 8'hFF;
  localparam logic [15:0] HALF_RST = 16'h0000;

endpackage

// File: rtl/leds_timebase.sv
// Shared timebase: prescaler tick, PWM ramp counter and blink phase.
module leds_timebase #(
  parameter int PWM_BITS = 4,
  parameter int PRESCALE = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         half,
  input  logic                half_wr,
  output logic                tick,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                blink_phase
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  always_comb begin
    tick          = (presc_q == PRESC_MAX);
    presc_d       = tick ? '0 : presc_q + PW'(1);
    pwm_cnt_d     = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    // A HALF write restarts the blink period in the on phase.
    if (half_wr) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (half == 16'd0) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == half - 16'd1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign pwm_cnt     = pwm_cnt_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: rtl/leds_pwm.sv
// Memory-mapped LED controller: register file, read mux and
// per-LED PWM/blink output stage.
module leds_pwm
  import leds_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 4,
  parameter int PRESCALE = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_en,
  input  logic [1:0]          addr,
  input  logic [15:0]         data,
  output logic [15:0]         rd_data,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  logic [NUM_LEDS-1:0] on_q, on_d;
  logic [NUM_LEDS-1:0] blink_q, blink_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [15:0]         half_q, half_d;
  logic [15:0]         rd_data_q, rd_data_d;
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;
  logic                half_wr;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink_phase;
  logic                pwm_on;

  leds_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_tb (
    .clk         (clk),
    .rst         (rst),
    .half        (half_q),
    .half_wr     (half_wr),
    .tick        (),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase)
  );

  always_comb begin
    on_d      = on_q;
    blink_d   = blink_q;
    duty_d    = duty_q;
    half_d    = half_q;
    rd_data_d = rd_data_q;
    half_wr   = 1'b0;
    if (en && wr_en) begin
      unique case (addr)
        ADDR_ON:    on_d    = data[NUM_LEDS-1:0];
        ADDR_BLINK: blink_d = data[NUM_LEDS-1:0];
        ADDR_DUTY:  duty_d  = data[PWM_BITS-1:0];
        ADDR_HALF: begin
          half_d  = data;
          half_wr = 1'b1;
        end
      endcase
    end else if (en) begin
      unique case (addr)
        ADDR_ON:    rd_data_d = 16'(on_q);
        ADDR_BLINK: rd_data_d = 16'(blink_q);
        ADDR_DUTY:  rd_data_d = 16'(duty_q);
        ADDR_HALF:  rd_data_d = half_q;
      endcase
    end
  end

  // Full-scale duty closes the one-step gap of the plain compare.
  always_comb begin
    pwm_on    = (duty_q == DUTY_FULL) || (pwm_cnt < duty_q);
    led_out_d = on_q & {NUM_LEDS{pwm_on}}
              & (~blink_q | {NUM_LEDS{blink_phase}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_q      <= '0;
      blink_q   <= '0;
      duty_q    <= DUTY_RST[PWM_BITS-1:0];
      half_q    <= HALF_RST;
      rd_data_q <= '0;
      led_out_q <= '0;
    end else begin
      on_q      <= on_d;
      blink_q   <= blink_d;
      duty_q    <= duty_d;
      half_q    <= half_d;
      rd_data_q <= rd_data_d;
      led_out_q <= led_out_d;
    end
  end

  assign rd_data = rd_data_q;
  assign led_out = led_out_q;

endmodule

// File: tb/tb_leds_pwm.sv
// Directed scoreboard bench for leds_pwm (PRESCALE=4, PWM_BITS=4, 8 LEDs).
module tb_leds_pwm;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] data;
  logic [15:0] rd_data;
  logic [7:0]  led_out;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  leds_pwm #(
    .NUM_LEDS (8),
    .PWM_BITS (4),
    .PRESCALE (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr_en   (wr_en),
    .addr    (addr),
    .data    (data),
    .rd_data (rd_data),
    .led_out (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    en = 1'b1; wr_en = 1'b1; addr = a; data = d;
    @(negedge clk);
    en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag,
                    input logic [15:0] e);
    @(negedge clk);
    en = 1'b1; wr_en = 1'b0; addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    en = 1'b0;
    chk(tag, rd_data);
  endtask

  task automatic count_full(input string tag, input logic [15:0] e);
    int n;
    n = 0;
    exp_q.push_back(e);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (led_out == 8'hFF) n++;
    end
    chk(tag, 16'(n));
  endtask

  initial begin
    int last, ntrans, found, steady;
    logic prev, bit1_ok;

    rst = 1'b1; en = 1'b0; wr_en = 1'b0; addr = '0; data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(16'h0000); chk("reset_led", 16'(led_out));
    exp_q.push_back(16'h0000); chk("reset_rd", rd_data);

    // 1. async reset between edges
    wr(2'd0, 16'h00FF);
    rd(2'd0, "pre_rst_rd_on", 16'h00FF);
    exp_q.push_back(16'h00FF); chk("pre_rst_led", 16'(led_out));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(16'h0000); chk("async_rst_led", 16'(led_out));
    exp_q.push_back(16'h0000); chk("async_rst_rd", rd_data);
    @(negedge clk);
    rst = 1'b0;
    rd(2'd2, "rst_duty", 16'h000F);
    rd(2'd0, "rst_on", 16'h0000);
    rd(2'd3, "rst_half", 16'h0000);

    // 2. direct write, upper data bits dropped
    wr(2'd0, 16'h12A5);
    exp_q.push_back(16'h0000); chk("on_not_yet", 16'(led_out));
    @(negedge clk);
    exp_q.push_back(16'h00A5); chk("on_visible", 16'(led_out));
    rd(2'd0, "rd_on_a5", 16'h00A5);

    // 3. PWM duty
    wr(2'd0, 16'h00FF);
    wr(2'd2, 16'h0004);
    @(negedge clk);
    count_full("duty4_cycles", 16'd16);
    wr(2'd2, 16'h0000);
    @(negedge clk);
    count_full("duty0_cycles", 16'd0);
    wr(2'd2, 16'h0001);
    @(negedge clk);
    count_full("duty1_cycles", 16'd4);
    wr(2'd2, 16'h000F);
    @(negedge clk);
    count_full("duty15_cycles", 16'd64);

    // 4. blink
    wr(2'd0, 16'h0003);
    wr(2'd1, 16'h0001);
    wr(2'd3, 16'h0002);
    @(negedge clk);
    exp_q.push_back(16'h0003); chk("blink_first_on", 16'(led_out));
    prev = led_out[0]; last = -1; ntrans = 0; bit1_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (!led_out[1]) bit1_ok = 1'b0;
      if (led_out[0] != prev) begin
        if (last >= 0) begin
          exp_q.push_back(16'd8);
          chk("blink_period", 16'(i - last));
        end
        last = i; ntrans++;
        prev = led_out[0];
      end
    end
    exp_q.push_back(16'd1); chk("blink_bit1_steady", 16'(bit1_ok));
    exp_q.push_back(16'd1); chk("blink_toggles", 16'(ntrans >= 4));

    // 5. en gating
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      en = 1'b0; wr_en = 1'b1; addr = 2'(a); data = 16'h00FF;
      @(negedge clk);
      wr_en = 1'b0;
    end
    rd(2'd0, "gate_on", 16'h0003);
    rd(2'd1, "gate_blink", 16'h0001);
    rd(2'd2, "gate_duty", 16'h000F);
    rd(2'd3, "gate_half", 16'h0002);

    // reset while bit0 is in its off phase
    found = 0;
    for (int i = 0; i < 32 && found == 0; i++) begin
      @(negedge clk);
      if (!led_out[0]) found = 1;
    end
    exp_q.push_back(16'd1); chk("blink_off_seen", 16'(found));
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(16'h0000); chk("mid_blink_rst_led", 16'(led_out));
    @(negedge clk);
    rst = 1'b0;
    wr(2'd0, 16'h0001);
    wr(2'd1, 16'h0001);
    @(negedge clk);
    exp_q.push_back(16'h0001); chk("phase_after_rst", 16'(led_out));
    steady = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (led_out != 8'h01) steady = 0;
    end
    exp_q.push_back(16'd1); chk("phase_held_half0", 16'(steady));

    // 6. read latency and hold
    wr(2'd3, 16'hBEEF);
    rd(2'd3, "rd_half_beef", 16'hBEEF);
    @(negedge clk);
    addr = 2'd0;
    repeat (3) @(negedge clk);
    exp_q.push_back(16'hBEEF); chk("rd_hold_en0", rd_data);
    wr(2'd0, 16'h005A);
    exp_q.push_back(16'hBEEF); chk("rd_hold_on_write", rd_data);
    rd(2'd0, "rd_on_5a", 16'h005A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
